huff_codebook_gen: RTL and testbench
====================================

Name: huff_codebook_gen

Overview:
Parametrised next-generation Huffman codebook generator. It accepts a stream of (symbol, frequency) entries over a valid/ready handshake and builds the Huffman tree sequentially. It then assigns canonical codes and streams out one (symbol, code, length) entry per symbol. It replaces the fixed-size, handshake-less encoder: symbol count and widths are generic, output is backpressurable, and single-symbol, zero-frequency and overflow inputs are handled explicitly.

Parameters:
MAX_SYMS, 8, maximum distinct symbols per table (>=2)
SYM_W, 8, symbol width in bits
FREQ_W, 8, input frequency width in bits
CODE_W, MAX_SYMS-1, code register width; equals the worst-case Huffman depth
LEN_W, $clog2(MAX_SYMS), code-length field width

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  input entry valid
in_ready  out  1  block can accept an entry
in_sym  in  SYM_W  symbol
in_freq  in  FREQ_W  symbol frequency
in_last  in  1  final entry of the table
out_valid  out  1  output entry valid
out_ready  in  1  consumer accepts the entry
out_sym  out  SYM_W  symbol
out_code  out  CODE_W  canonical code, right-aligned (LSB-justified)
out_len  out  LEN_W  code length in bits
out_last  out  1  final output entry
busy  out  1  high in any state other than LOAD
done  out  1  one-cycle pulse when a table completes
err_overflow  out  1  sticky; more than MAX_SYMS nonzero entries were offered
err_empty  out  1  sticky; table closed with zero accepted symbols

Behaviour:
- Reset (reset==0 at a clock edge), from any state including mid-operation:
  - state goes to LOAD.
  - in_ready=1, out_valid=0, out_last=0, busy=0, done=0, errors=0.
  - out_sym, out_code and out_len are 0.
  - Symbol count n=0; node table cleared.
- States: LOAD -> BUILD -> DEPTH -> ASSIGN -> EMIT -> LOAD.
- LOAD: in_ready=1. A handshake is in_valid && in_ready.
  - Entry with in_freq==0: discarded, not counted.
  - Entry while n==MAX_SYMS: discarded; err_overflow set.
  - Otherwise: stored as leaf n; n increments.
  - Duplicate symbols are stored as distinct leaves; no check is made.
  - When the in_last handshake has been processed:
    - n>=2: go to BUILD.
    - n==1: go to ASSIGN with that leaf forced to length 1.
    - n==0: set err_empty, pulse done, stay in LOAD, emit nothing.
- BUILD: exactly n-1 cycles.
  - Each cycle, select the two active nodes of smallest weight. Ties go to the lower node index; the first pick is the smaller.
  - Create internal node index n+k (k = merge count) with weight = sum and record parent pointers.
  - Deactivate both picked nodes.
  - Weight width is FREQ_W+$clog2(MAX_SYMS); this width cannot overflow.
- DEPTH: exactly 2n-1 cycles.
  - Walk node indices from the root (2n-2) down to 0.
  - depth[root]=0; otherwise depth[i]=depth[parent[i]]+1. A parent index is always greater than the child's.
- ASSIGN: exactly CODE_W*MAX_SYMS cycles.
  - Loop L=1..CODE_W, outer; inner loop over leaf slots 0..MAX_SYMS-1 in load order.
  - If leaf j is valid and depth==L: code[j]=c, then c++.
  - At the end of each L: c=c<<1. c starts at 0.
  - Result is standard canonical Huffman: shorter codes first, ties broken by load order.
- EMIT: entries are presented in load order.
  - out_valid=1 throughout; the entry advances on out_valid && out_ready.
  - All out_* signals are held stable while out_ready==0.
  - out_last=1 on entry n-1.
  - The handshake on the last entry returns the block to LOAD, pulses done in the same cycle, and clears n. Error flags persist until reset.
- in_ready=0 in every state except LOAD. in_valid is ignored there and input is never lost silently, because the producer must hold it.
- Code bits above out_len are 0.

Decomposition:
- Package huff_pkg holds:
  - the state enum;
  - node_t struct (weight, parent index, active, is_leaf);
  - width helper constants (WGT_W, IDX_W=$clog2(2*MAX_SYMS-1)).
- One combinational sub-module, huff_min2. It scans the active mask and weights, and returns the two minimum indices with lowest-index tie-break. This keeps the search isolated for reuse and for unit testing.

Test Plan:
- T1 "abc": a=1, b=2, c=1, last on c, out_ready=1.
  - Required output: a len2 code 10; b len1 code 0; c len2 code 11, out_last.
  - done pulses once; busy returns to 0.
- T2 single symbol: a, freq 5.
  - Required output: one entry a len1 code 0, out_last=1; no errors.
- T3 "aabb": a=2, b=2.
  - Required output: a len1 code 0; b len1 code 1.
- T4 limits: 9 nonzero entries, plus one freq-0 entry, with MAX_SYMS=8.
  - Required: err_overflow=1; the freq-0 and 9th entries are absent; exactly 8 entries emitted; code lengths satisfy Kraft sum == 1.
- T5 backpressure: T1 stimulus with out_ready=0 for 5 cycles after the first out_valid.
  - Required: out_sym/out_code/out_len stable throughout the stall; order and values unchanged afterwards.
- T6 reset: assert reset=0 for one cycle during BUILD.
  - Required, next cycle: in_ready=1, busy=0, out_valid=0, errors=0.
  - A subsequent T3 stimulus must produce T3's results.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared types and sizing for the Huffman codebook generator.
package huff_pkg;

  localparam int unsigned HUFF_MAX_SYMS = 8;
  localparam int unsigned HUFF_FREQ_W   = 8;
  localparam int unsigned HUFF_NODES    = 2 * HUFF_MAX_SYMS - 1;
  localparam int unsigned WGT_W         = HUFF_FREQ_W + $clog2(HUFF_MAX_SYMS);
  localparam int unsigned IDX_W         = $clog2(2 * HUFF_MAX_SYMS - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_BUILD,
    S_DEPTH,
    S_ASSIGN,
    S_EMIT
  } state_t;

  typedef struct packed {
    logic [WGT_W-1:0] weight;
    logic [IDX_W-1:0] parent;
    logic             active;
    logic             is_leaf;
  } node_t;

endpackage

// File: rtl/huff_codebook_gen_min2.sv
// Combinational search for the two lightest active nodes (lower index wins ties).
module huff_min2
  import huff_pkg::*;
#(
  parameter int unsigned P_NODES = HUFF_NODES,
  parameter int unsigned P_WGT_W = WGT_W,
  parameter int unsigned P_IDX_W = IDX_W
)(
  input  logic [P_NODES-1:0]              i_active,
  input  logic [P_NODES-1:0][P_WGT_W-1:0] i_wgt,
  output logic [P_IDX_W-1:0]              o_min0_c,
  output logic [P_IDX_W-1:0]              o_min1_c
);

  logic               w_found0;
  logic               w_found1;
  logic [P_WGT_W-1:0] w_best0;
  logic [P_WGT_W-1:0] w_best1;

  // Two linear scans; the strict compare keeps the first (lowest) index on equal weights.
  always_comb begin
    w_found0 = 1'b0;
    w_best0  = '0;
    o_min0_c = '0;
    w_found1 = 1'b0;
    w_best1  = '0;
    o_min1_c = '0;
    for (int i = 0; i < int'(P_NODES); i++) begin
      if (i_active[i] && (!w_found0 || (i_wgt[i] < w_best0))) begin
        w_found0 = 1'b1;
        w_best0  = i_wgt[i];
        o_min0_c = P_IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(P_NODES); i++) begin
      if (i_active[i] && (P_IDX_W'(i) != o_min0_c) &&
          (!w_found1 || (i_wgt[i] < w_best1))) begin
        w_found1 = 1'b1;
        w_best1  = i_wgt[i];
        o_min1_c = P_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/huff_codebook_gen.sv
// Huffman codebook generator: load (symbol, freq), build tree, depth walk,
// canonical code assignment, then stream (symbol, code, length) in load order.
module huff_codebook_gen
  import huff_pkg::*;
#(
  parameter int unsigned MAX_SYMS = HUFF_MAX_SYMS,
  parameter int unsigned SYM_W    = 8,
  parameter int unsigned FREQ_W   = HUFF_FREQ_W,
  parameter int unsigned CODE_W   = MAX_SYMS - 1,
  parameter int unsigned LEN_W    = $clog2(MAX_SYMS)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SYM_W-1:0]  in_sym,
  input  logic [FREQ_W-1:0] in_freq,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_sym,
  output logic [CODE_W-1:0] out_code,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_empty
);

  localparam int unsigned N_NODES = 2 * MAX_SYMS - 1;
  localparam int unsigned SLOT_W  = $clog2(MAX_SYMS);
  localparam int unsigned C_W     = CODE_W + 1;

  state_t              r_state;
  node_t               r_node  [N_NODES];
  logic [LEN_W-1:0]    r_depth [N_NODES];
  logic [SYM_W-1:0]    r_sym   [MAX_SYMS];
  logic [CODE_W-1:0]   r_code  [MAX_SYMS];
  logic [IDX_W-1:0]    r_n;
  logic [IDX_W-1:0]    r_k;
  logic [IDX_W-1:0]    r_idx;
  logic [LEN_W-1:0]    r_len_l;
  logic [SLOT_W-1:0]   r_j;
  logic [C_W-1:0]      r_c;
  logic [SLOT_W-1:0]   r_e;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_out_valid;
  logic                r_out_last;
  logic [SYM_W-1:0]    r_out_sym;
  logic [CODE_W-1:0]   r_out_code;
  logic [LEN_W-1:0]    r_out_len;
  logic                r_done;
  logic                r_err_ovf;
  logic                r_err_empty;

  logic [N_NODES-1:0]            w_active;
  logic [N_NODES-1:0][WGT_W-1:0] w_wgt;
  logic [IDX_W-1:0]              w_min0;
  logic [IDX_W-1:0]              w_min1;
  logic                          w_store;
  logic [IDX_W-1:0]              w_n_next;
  logic [IDX_W-1:0]              w_new;
  logic [IDX_W-1:0]              w_root;
  logic                          w_hit;
  logic [C_W-1:0]                w_c_inc;
  logic [SLOT_W-1:0]             w_e_next;

  // Flatten the node table for the minimum search.
  always_comb begin
    for (int i = 0; i < int'(N_NODES); i++) begin
      w_active[i] = r_node[i].active;
      w_wgt[i]    = r_node[i].weight;
    end
  end

  huff_min2 #(
    .P_NODES (N_NODES),
    .P_WGT_W (WGT_W),
    .P_IDX_W (IDX_W)
  ) u_min2 (
    .i_active (w_active),
    .i_wgt    (w_wgt),
    .o_min0_c (w_min0),
    .o_min1_c (w_min1)
  );

  assign w_store  = (in_freq != '0) && (r_n != IDX_W'(MAX_SYMS));
  assign w_n_next = w_store ? (r_n + IDX_W'(1)) : r_n;
  assign w_new    = r_n + r_k;
  assign w_root   = (r_n << 1) - IDX_W'(2);
  assign w_hit    = r_node[IDX_W'(r_j)].is_leaf && (r_depth[IDX_W'(r_j)] == r_len_l);
  assign w_c_inc  = r_c + C_W'(w_hit);
  assign w_e_next = r_e + SLOT_W'(1);

  // Control FSM with the node table, code table and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_LOAD;
      r_n         <= '0;
      r_k         <= '0;
      r_idx       <= '0;
      r_len_l     <= '0;
      r_j         <= '0;
      r_c         <= '0;
      r_e         <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_sym   <= '0;
      r_out_code  <= '0;
      r_out_len   <= '0;
      r_done      <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_empty <= 1'b0;
      for (int i = 0; i < int'(N_NODES); i++) begin
        r_node[i]  <= '0;
        r_depth[i] <= '0;
      end
      for (int j = 0; j < int'(MAX_SYMS); j++) begin
        r_sym[j]  <= '0;
        r_code[j] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_LOAD: begin
          if (in_valid && r_in_ready) begin
            if (in_freq != '0 && !w_store) begin
              r_err_ovf <= 1'b1;
            end
            if (w_store) begin
              r_node[r_n]            <= '{weight: WGT_W'(in_freq), parent: '0,
                                          active: 1'b1, is_leaf: 1'b1};
              r_sym[SLOT_W'(r_n)]    <= in_sym;
              r_n                    <= w_n_next;
            end
            if (in_last) begin
              if (w_n_next >= IDX_W'(2)) begin
                r_state    <= S_BUILD;
                r_k        <= '0;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b1;
              end else if (w_n_next == IDX_W'(1)) begin
                // A lone symbol still needs a one-bit code.
                r_state    <= S_ASSIGN;
                r_depth[0] <= LEN_W'(1);
                r_len_l    <= LEN_W'(1);
                r_j        <= '0;
                r_c        <= '0;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b1;
              end else begin
                r_err_empty <= 1'b1;
                r_done      <= 1'b1;
              end
            end
          end
        end
        S_BUILD: begin
          r_node[w_min0].active <= 1'b0;
          r_node[w_min0].parent <= w_new;
          r_node[w_min1].active <= 1'b0;
          r_node[w_min1].parent <= w_new;
          r_node[w_new]         <= '{weight: w_wgt[w_min0] + w_wgt[w_min1], parent: '0,
                                     active: 1'b1, is_leaf: 1'b0};
          r_k <= r_k + IDX_W'(1);
          if (r_k == r_n - IDX_W'(2)) begin
            r_state <= S_DEPTH;
            r_idx   <= w_new;
          end
        end
        S_DEPTH: begin
          // Parents always sit above children, so a top-down walk sees them first.
          if (r_idx == w_root) begin
            r_depth[r_idx] <= '0;
          end else begin
            r_depth[r_idx] <= r_depth[r_node[r_idx].parent] + LEN_W'(1);
          end
          r_idx <= r_idx - IDX_W'(1);
          if (r_idx == '0) begin
            r_state <= S_ASSIGN;
            r_len_l <= LEN_W'(1);
            r_j     <= '0;
            r_c     <= '0;
          end
        end
        S_ASSIGN: begin
          if (w_hit) begin
            r_code[r_j] <= CODE_W'(r_c);
          end
          if (r_j == SLOT_W'(MAX_SYMS - 1)) begin
            r_c     <= w_c_inc << 1;
            r_j     <= '0;
            r_len_l <= r_len_l + LEN_W'(1);
            if (r_len_l == LEN_W'(CODE_W)) begin
              r_state     <= S_EMIT;
              r_e         <= '0;
              r_out_valid <= 1'b1;
              r_out_sym   <= r_sym[0];
              r_out_code  <= r_code[0];
              r_out_len   <= r_depth[0];
              r_out_last  <= (r_n == IDX_W'(1));
            end
          end else begin
            r_c <= w_c_inc;
            r_j <= r_j + SLOT_W'(1);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_state     <= S_LOAD;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_done      <= 1'b1;
              r_n         <= '0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              for (int i = 0; i < int'(N_NODES); i++) begin
                r_node[i] <= '0;
              end
            end else begin
              r_e        <= w_e_next;
              r_out_sym  <= r_sym[w_e_next];
              r_out_code <= r_code[w_e_next];
              r_out_len  <= r_depth[IDX_W'(w_e_next)];
              r_out_last <= (IDX_W'(w_e_next) == r_n - IDX_W'(1));
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign out_sym      = r_out_sym;
  assign out_code     = r_out_code;
  assign out_len      = r_out_len;
  assign done         = r_done;
  assign err_overflow = r_err_ovf;
  assign err_empty    = r_err_empty;

endmodule

// File: tb/tb_huff_codebook_gen.sv
// Bench for huff_codebook_gen: directed scenarios plus random tables vs a reference model.
module tb_huff_codebook_gen;

  localparam int MAX_SYMS = 8;
  localparam int SYM_W    = 8;
  localparam int FREQ_W   = 8;
  localparam int CODE_W   = 7;
  localparam int LEN_W    = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SYM_W-1:0]  in_sym = '0;
  logic [FREQ_W-1:0] in_freq = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [SYM_W-1:0]  out_sym;
  logic [CODE_W-1:0] out_code;
  logic [LEN_W-1:0]  out_len;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err_overflow;
  logic              err_empty;

  always #5 clk = ~clk;

  huff_codebook_gen dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sym       (in_sym),
    .in_freq      (in_freq),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sym      (out_sym),
    .out_code     (out_code),
    .out_len      (out_len),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow),
    .err_empty    (err_empty)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // stimulus table
  logic [7:0] t_sym [16];
  int         t_freq[16];
  int         t_cnt;

  // reference model results
  int         m_n;
  logic [7:0] m_sym [16];
  int         m_freq[16];
  int         m_len [16];
  int         m_code[16];
  bit         m_ovf;

  // captured output
  logic [31:0] g_sym [16];
  logic [31:0] g_code[16];
  logic [31:0] g_len [16];
  logic        g_last[16];
  int          g_cnt;
  bit          g_to;
  bit          stall_changed;
  bit          stall_seen;

  // Huffman by repeated merging; a leaf's length is the number of merges its subtree joins.
  function automatic void model_prepare();
    int         w   [32];
    bit         act [32];
    bit [15:0]  mask[32];
    int         a, b, nn, code, prev;
    bit         first;
    m_n = 0;
    m_ovf = 0;
    for (int i = 0; i < t_cnt; i++) begin
      if (t_freq[i] != 0) begin
        if (m_n == MAX_SYMS) m_ovf = 1;
        else begin
          m_sym[m_n]  = t_sym[i];
          m_freq[m_n] = t_freq[i];
          m_n++;
        end
      end
    end
    for (int i = 0; i < 32; i++) begin
      w[i] = 0; act[i] = 0; mask[i] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      m_len[i] = 0; m_code[i] = 0;
    end
    for (int i = 0; i < m_n; i++) begin
      w[i] = m_freq[i]; act[i] = 1; mask[i] = 16'(1) << i;
    end
    if (m_n == 1) m_len[0] = 1;
    for (int k = 0; k < m_n - 1; k++) begin
      a = -1; b = -1;
      for (int i = 0; i < m_n + k; i++)
        if (act[i] && (a < 0 || w[i] < w[a])) a = i;
      for (int i = 0; i < m_n + k; i++)
        if (act[i] && i != a && (b < 0 || w[i] < w[b])) b = i;
      nn = m_n + k;
      w[nn] = w[a] + w[b];
      act[nn] = 1; act[a] = 0; act[b] = 0;
      mask[nn] = mask[a] | mask[b];
      for (int j = 0; j < m_n; j++) if (mask[nn][j]) m_len[j]++;
    end
    code = 0; prev = 0; first = 1;
    for (int l = 1; l <= CODE_W; l++) begin
      for (int j = 0; j < m_n; j++) begin
        if (m_len[j] == l) begin
          if (first) begin code = 0; first = 0; end
          else code = (code + 1) << (l - prev);
          prev = l;
          m_code[j] = code;
        end
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_table();
    for (int i = 0; i < t_cnt; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sym   = t_sym[i];
      in_freq  = FREQ_W'(t_freq[i]);
      in_last  = (i == t_cnt - 1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: always ready, 1: five-cycle stall on first entry, 2: random ready
  task automatic collect(input int mode);
    int         stall;
    logic [31:0] s_sym, s_code, s_len;
    g_cnt = 0; g_to = 1; stall = 0; stall_changed = 0; stall_seen = 0;
    s_sym = '0; s_code = '0; s_len = '0;
    for (int i = 0; i < 16; i++) begin
      g_sym[i] = '1; g_code[i] = '1; g_len[i] = '1; g_last[i] = 1'b0;
    end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (mode == 1 && out_valid === 1'b1 && !stall_seen) begin
        stall_seen = 1; stall = 5;
        s_sym = 32'(out_sym); s_code = 32'(out_code); s_len = 32'(out_len);
      end
      if (stall > 0) begin
        out_ready = 1'b0;
        if (out_valid !== 1'b1 || 32'(out_sym) !== s_sym ||
            32'(out_code) !== s_code || 32'(out_len) !== s_len) stall_changed = 1;
        stall--;
      end else if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        if (g_cnt < 16) begin
          g_sym[g_cnt]  = 32'(out_sym);
          g_code[g_cnt] = 32'(out_code);
          g_len[g_cnt]  = 32'(out_len);
          g_last[g_cnt] = out_last;
        end
        g_cnt++;
        if (out_last === 1'b1) begin
          g_to = 0;
          break;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
  endtask

  task automatic load_abc();
    t_cnt = 3;
    t_sym[0] = 8'h61; t_freq[0] = 1;
    t_sym[1] = 8'h62; t_freq[1] = 2;
    t_sym[2] = 8'h63; t_freq[2] = 1;
  endtask

  task automatic load_aabb();
    t_cnt = 2;
    t_sym[0] = 8'h61; t_freq[0] = 2;
    t_sym[1] = 8'h62; t_freq[1] = 2;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got valid=%b last=%b done=%b want 0", out_valid, out_last, done); end
    n_tests++; if (err_overflow !== 1'b0 || err_empty !== 1'b0) begin
      n_fail++; $display("FAIL reset_errs got ovf=%b empty=%b want 0", err_overflow, err_empty); end
    n_tests++; if (out_sym !== '0 || out_code !== '0 || out_len !== '0) begin
      n_fail++; $display("FAIL reset_data got sym=%h code=%h len=%0d want 0", out_sym, out_code, out_len); end
  endtask

  task automatic test_abc(input int mode);
    int es[3], el[3], ec[3];
    int d0;
    es = '{97, 98, 99}; el = '{2, 1, 2}; ec = '{2, 0, 3};
    do_reset();
    load_abc();
    d0 = done_cnt;
    send_table();
    collect(mode);
    repeat (3) @(negedge clk);
    n_tests++; if (g_to || g_cnt != 3) begin n_fail++; $display("FAIL abc_count m%0d got %0d timeout=%0d want 3", mode, g_cnt, g_to); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (g_sym[i] !== 32'(es[i]) || g_len[i] !== 32'(el[i]) || g_code[i] !== 32'(ec[i]) || g_last[i] !== (i == 2)) begin
        n_fail++;
        $display("FAIL abc_entry%0d m%0d got sym=%0h len=%0d code=%0h last=%b want sym=%0h len=%0d code=%0h last=%b",
                 i, mode, g_sym[i], g_len[i], g_code[i], g_last[i], es[i], el[i], ec[i], (i == 2));
      end
    end
    n_tests++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL abc_done m%0d got %0d pulses want 1", mode, done_cnt - d0); end
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL abc_idle m%0d got busy=%b in_ready=%b want 0/1", mode, busy, in_ready); end
    if (mode == 1) begin
      n_tests++; if (!stall_seen || stall_changed) begin
        n_fail++; $display("FAIL stall_stable got seen=%0d changed=%0d want 1/0", stall_seen, stall_changed); end
    end
  endtask

  task automatic test_single();
    do_reset();
    t_cnt = 1; t_sym[0] = 8'h61; t_freq[0] = 5;
    send_table();
    collect(0);
    n_tests++;
    if (g_to || g_cnt != 1 || g_sym[0] !== 32'h61 || g_len[0] !== 32'd1 || g_code[0] !== 32'd0 || g_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL single got cnt=%0d sym=%0h len=%0d code=%0h last=%b want 1/61/1/0/1",
                          g_cnt, g_sym[0], g_len[0], g_code[0], g_last[0]);
    end
    n_tests++; if (err_overflow !== 1'b0 || err_empty !== 1'b0) begin
      n_fail++; $display("FAIL single_errs got ovf=%b empty=%b want 0", err_overflow, err_empty); end
  endtask

  task automatic test_aabb(input string tag);
    load_aabb();
    send_table();
    collect(0);
    n_tests++;
    if (g_to || g_cnt != 2 || g_sym[0] !== 32'h61 || g_len[0] !== 32'd1 || g_code[0] !== 32'd0 ||
        g_sym[1] !== 32'h62 || g_len[1] !== 32'd1 || g_code[1] !== 32'd1 || g_last[1] !== 1'b1) begin
      n_fail++; $display("FAIL %s got cnt=%0d e0=%0h/%0d/%0h e1=%0h/%0d/%0h want 2 e0=61/1/0 e1=62/1/1",
                          tag, g_cnt, g_sym[0], g_len[0], g_code[0], g_sym[1], g_len[1], g_code[1]);
    end
  endtask

  task automatic test_empty();
    int d0;
    bit seen;
    do_reset();
    t_cnt = 1; t_sym[0] = 8'h33; t_freq[0] = 0;
    d0 = done_cnt; seen = 0;
    send_table();
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    n_tests++; if (err_empty !== 1'b1) begin n_fail++; $display("FAIL empty_flag got %b want 1", err_empty); end
    n_tests++; if (done_cnt - d0 != 1 || seen || busy !== 1'b0) begin
      n_fail++; $display("FAIL empty_behaviour got done=%0d outv_seen=%0d busy=%b want 1/0/0", done_cnt - d0, seen, busy); end
  endtask

  task automatic test_limits();
    int ks;
    int li;
    do_reset();
    t_cnt = 10;
    for (int i = 0; i < 10; i++) begin
      t_sym[i]  = 8'(8'h10 + i);
      t_freq[i] = (i == 4) ? 0 : int'($urandom_range(1, 60));
    end
    model_prepare();
    send_table();
    collect(0);
    n_tests++; if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL limits_ovf got %b want 1", err_overflow); end
    n_tests++; if (g_to || g_cnt != 8) begin n_fail++; $display("FAIL limits_count got %0d timeout=%0d want 8", g_cnt, g_to); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (g_sym[i] !== 32'(m_sym[i]) || g_len[i] !== 32'(m_len[i]) || g_code[i] !== 32'(m_code[i])) begin
        n_fail++; $display("FAIL limits_entry%0d got sym=%0h len=%0d code=%0h want sym=%0h len=%0d code=%0h",
                            i, g_sym[i], g_len[i], g_code[i], m_sym[i], m_len[i], m_code[i]);
      end
    end
    ks = 0;
    for (int i = 0; i < 8; i++) begin
      li = int'(g_len[i]);
      if (li >= 1 && li <= CODE_W) ks += 1 << (CODE_W - li);
      else ks += 1000;
    end
    n_tests++; if (ks != (1 << CODE_W)) begin n_fail++; $display("FAIL limits_kraft got %0d want %0d", ks, 1 << CODE_W); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    t_cnt = 6;
    for (int i = 0; i < 6; i++) begin
      t_sym[i] = 8'(8'h41 + i); t_freq[i] = int'($urandom_range(1, 200));
    end
    send_table();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy got %b want 1", busy); end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || err_overflow !== 1'b0 || err_empty !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state got rdy=%b busy=%b ov=%b eo=%b ee=%b want 1/0/0/0/0",
                          in_ready, busy, out_valid, err_overflow, err_empty);
    end
    reset = 1'b1;
    test_aabb("midrst_aabb");
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      do_reset();
      t_cnt = int'($urandom_range(1, 10));
      for (int i = 0; i < t_cnt; i++) begin
        t_sym[i]  = 8'($urandom);
        t_freq[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
      end
      if (t_freq[0] == 0) t_freq[0] = 1;
      model_prepare();
      send_table();
      collect(2);
      n_tests++; if (g_to || g_cnt != m_n) begin
        n_fail++; $display("FAIL rand%0d_count got %0d timeout=%0d want %0d", it, g_cnt, g_to, m_n); end
      for (int i = 0; i < m_n; i++) begin
        n_tests++;
        if (g_sym[i] !== 32'(m_sym[i]) || g_len[i] !== 32'(m_len[i]) || g_code[i] !== 32'(m_code[i]) ||
            g_last[i] !== (i == m_n - 1)) begin
          n_fail++; $display("FAIL rand%0d_entry%0d got sym=%0h len=%0d code=%0h last=%b want sym=%0h len=%0d code=%0h",
                              it, i, g_sym[i], g_len[i], g_code[i], g_last[i], m_sym[i], m_len[i], m_code[i]);
        end
      end
      n_tests++; if (err_overflow !== m_ovf || err_empty !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_errs got ovf=%b empty=%b want %0d/0", it, err_overflow, err_empty, m_ovf); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish, %0d of %0d", n_fail, n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_abc(0);
    test_single();
    do_reset();
    test_aabb("aabb");
    test_empty();
    test_limits();
    test_abc(1);
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
